// File: rtl/dmgplus_pkg.sv
// Shared constants for the DMG-style pixel path: default raster size, shade encoding,
// quantiser arithmetic and (only when PIX_QUANTIZER_DITHER_EN is defined) the 4x4 Bayer table.
package dmgplus_pkg;

    localparam int H_ACTIVE_DEFAULT = 160;
    localparam int V_ACTIVE_DEFAULT = 144;

    localparam logic [3:0] MAX_LUMA   = 4'd11;
    localparam logic [3:0] ROUND_BIAS = 4'd6;

    typedef enum logic [1:0] {
        SHADE_LIGHTEST = 2'd0,
        SHADE_LIGHT    = 2'd1,
        SHADE_DARK     = 2'd2,
        SHADE_DARKEST  = 2'd3
    } shade_e;

    // Quantised brightness level q (0..3) maps inversely onto the DMG shade.
    function automatic shade_e shadeFromLevel(input logic [1:0] level);
        return shade_e'(2'd3 - level);
    endfunction

    // q = min(3, floor((v*4 + d) / 12)); v is already clamped to 0..11.
    function automatic logic [1:0] quantLevel(input logic [3:0] luma, input logic [3:0] bias);
        logic [5:0] sum;
        logic [5:0] level;
        sum   = {luma, 2'b00} + {2'b00, bias};
        level = sum / 6'd12;
        return (level > 6'd3) ? 2'd3 : 2'(level);
    endfunction

`ifdef PIX_QUANTIZER_DITHER_EN
    function automatic logic [3:0] bayerEntry(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] entry;
        case ({row, col})
            4'h0: entry = 4'd0;   4'h1: entry = 4'd8;   4'h2: entry = 4'd2;   4'h3: entry = 4'd10;
            4'h4: entry = 4'd12;  4'h5: entry = 4'd4;   4'h6: entry = 4'd14;  4'h7: entry = 4'd6;
            4'h8: entry = 4'd3;   4'h9: entry = 4'd11;  4'hA: entry = 4'd1;   4'hB: entry = 4'd9;
            default: begin
                case (col)
                    2'd0:    entry = 4'd15;
                    2'd1:    entry = 4'd7;
                    2'd2:    entry = 4'd13;
                    default: entry = 4'd5;
                endcase
            end
        endcase
        return entry;
    endfunction

    // Rescale the 0..15 threshold onto the 0..11 bias range: (B*3)>>2.
    function automatic logic [3:0] bayerBias(input logic [1:0] row, input logic [1:0] col);
        logic [5:0] scaled;
        scaled = 6'(bayerEntry(row, col)) * 6'd3;
        return 4'(scaled >> 2);
    endfunction
`endif

endpackage

// File: rtl/pix_quantizer.sv
// Converts a 4-bit luminance pixel stream into registered 2-bit DMG VRAM writes.
// Define PIX_QUANTIZER_DITHER_EN for ordered (Bayer) dithering; otherwise plain rounding.
module pix_quantizer
    import dmgplus_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
    parameter int V_ACTIVE = V_ACTIVE_DEFAULT
) (
    input  logic        clk_8m,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [3:0]  in_data,
    input  logic        in_vstart,
    input  logic        in_hstart,
    output logic [15:0] vram_addr,
    output logic [1:0]  vram_data,
    output logic        vram_we,
    output logic        frame_done
);

    logic [7:0]  r_xPos;
    logic [7:0]  r_yPos;
    logic        r_sync;
    logic [15:0] r_vramAddr;
    logic [1:0]  r_vramData;
    logic        r_vramWe;
    logic        r_frameDone;

    logic [7:0]  w_xNext;
    logic [7:0]  w_yNext;
    logic        w_syncNext;
    logic [3:0]  w_luma;
    logic [3:0]  w_bias;
    logic        w_write;
    logic        w_lastPixel;
    shade_e      w_shade;

    // The coordinates computed here are those of the pixel being accepted this cycle.
    always_comb begin
        w_xNext    = r_xPos;
        w_yNext    = r_yPos;
        w_syncNext = r_sync;
        if (in_valid) begin
            if (in_vstart) begin
                w_xNext    = 8'd0;
                w_yNext    = 8'd0;
                w_syncNext = 1'b1;
            end else if (in_hstart) begin
                w_xNext = 8'd0;
                w_yNext = (r_yPos == 8'hFF) ? 8'hFF : r_yPos + 8'd1;
            end else begin
                w_xNext = (r_xPos == 8'hFF) ? 8'hFF : r_xPos + 8'd1;
            end
        end
    end

    assign w_luma = (in_data > MAX_LUMA) ? MAX_LUMA : in_data;

`ifdef PIX_QUANTIZER_DITHER_EN
    assign w_bias = bayerBias(w_yNext[1:0], w_xNext[1:0]);
`else
    assign w_bias = ROUND_BIAS;
`endif

    assign w_shade     = shadeFromLevel(quantLevel(w_luma, w_bias));
    assign w_write     = in_valid && w_syncNext
                         && (int'(w_xNext) < H_ACTIVE) && (int'(w_yNext) < V_ACTIVE);
    assign w_lastPixel = (int'(w_xNext) == H_ACTIVE - 1) && (int'(w_yNext) == V_ACTIVE - 1);

    // Address and data only move on a write, so they hold between strobes.
    always_ff @(posedge clk_8m or negedge rst_n) begin
        if (!rst_n) begin
            r_xPos      <= 8'd0;
            r_yPos      <= 8'd0;
            r_sync      <= 1'b0;
            r_vramAddr  <= 16'd0;
            r_vramData  <= 2'd0;
            r_vramWe    <= 1'b0;
            r_frameDone <= 1'b0;
        end else begin
            r_xPos      <= w_xNext;
            r_yPos      <= w_yNext;
            r_sync      <= w_syncNext;
            r_vramWe    <= w_write;
            r_frameDone <= w_write && w_lastPixel;
            if (w_write) begin
                r_vramAddr <= {w_yNext, w_xNext};
                r_vramData <= w_shade;
            end
        end
    end

    assign vram_addr  = r_vramAddr;
    assign vram_data  = r_vramData;
    assign vram_we    = r_vramWe;
    assign frame_done = r_frameDone;

endmodule

// File: tb/tb_pix_quantizer.sv
// Self-checking bench for pix_quantizer against a raster/arithmetic reference model.
// Honours PIX_QUANTIZER_DITHER_EN the same way the design does.
module tb_pix_quantizer;

    localparam int H = 160;
    localparam int V = 144;

    logic        clk_8m;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  in_data;
    logic        in_vstart;
    logic        in_hstart;
    logic [15:0] vram_addr;
    logic [1:0]  vram_data;
    logic        vram_we;
    logic        frame_done;

    int compared   = 0;
    int mismatched = 0;

    int  mX, mY;
    bit  mSync;
    logic        expWe, expFd;
    logic [15:0] expAddr;
    logic [1:0]  expData;

    int strobeCount, fdCount;
    logic [15:0] fdAddr;

    int bayer [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};

    pix_quantizer #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk_8m    (clk_8m),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_vstart (in_vstart),
        .in_hstart (in_hstart),
        .vram_addr (vram_addr),
        .vram_data (vram_data),
        .vram_we   (vram_we),
        .frame_done(frame_done)
    );

    initial clk_8m = 1'b0;
    always #5 clk_8m = ~clk_8m;

    task automatic checkVal(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [1:0] modelShade(input int luma, input int x, input int y);
        int v, d, q;
        v = (luma > 11) ? 11 : luma;
`ifdef PIX_QUANTIZER_DITHER_EN
        d = (bayer[y % 4][x % 4] * 3) / 4;
`else
        d = 6;
`endif
        q = (v * 4 + d) / 12;
        if (q > 3) q = 3;
        return 2'(3 - q);
    endfunction

    task automatic modelReset();
        mX = 0; mY = 0; mSync = 0;
        expWe = 0; expFd = 0; expAddr = 16'h0000; expData = 2'd0;
    endtask

    task automatic modelStep(input logic v, input logic [3:0] d, input logic vs, input logic hs);
        expWe = 0;
        expFd = 0;
        if (!v) return;
        if (vs) begin
            mX = 0; mY = 0; mSync = 1;
        end else if (hs) begin
            mX = 0; mY = (mY >= 255) ? 255 : mY + 1;
        end else begin
            mX = (mX >= 255) ? 255 : mX + 1;
        end
        if (mSync && mX < H && mY < V) begin
            expWe   = 1;
            expAddr = 16'(mY * 256 + mX);
            expData = modelShade(int'(d), mX, mY);
            expFd   = (mX == H - 1) && (mY == V - 1);
        end
    endtask

    task automatic checkOutput();
        checkVal("vram_we", 16'(vram_we), 16'(expWe));
        checkVal("frame_done", 16'(frame_done), 16'(expFd));
        checkVal("vram_addr", vram_addr, expAddr);
        checkVal("vram_data", 16'(vram_data), 16'(expData));
        if (vram_we === 1'b1) strobeCount++;
        if (frame_done === 1'b1) begin
            fdCount++;
            fdAddr = vram_addr;
        end
    endtask

    // Drive one cycle of input, then sample the registered result just after the edge.
    task automatic applyStimulus(input logic v, input logic [3:0] d, input logic vs, input logic hs);
        in_valid  = v;
        in_data   = d;
        in_vstart = vs;
        in_hstart = hs;
        modelStep(v, d, vs, hs);
        @(posedge clk_8m);
        #1;
        checkOutput();
        in_valid  = 1'b0;
        in_vstart = 1'b0;
        in_hstart = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = 4'd0; in_vstart = 1'b0; in_hstart = 1'b0;
        strobeCount = 0; fdCount = 0; fdAddr = 16'h0;
        modelReset();
        repeat (3) @(posedge clk_8m);
        #1;
        checkVal("reset_we", 16'(vram_we), 16'd0);
        checkVal("reset_fd", 16'(frame_done), 16'd0);
        checkVal("reset_addr", vram_addr, 16'h0000);
        checkVal("reset_data", 16'(vram_data), 16'd0);
        rst_n = 1'b1;

        // Pixels before any vstart are dropped.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'(i), 1'b0, 1'b0);
        checkVal("pre_sync_strobes", 16'(strobeCount), 16'd0);

        applyStimulus(1'b1, 4'd0, 1'b1, 1'b0);
        checkVal("vstart_d0_addr", vram_addr, 16'h0000);
        checkVal("vstart_d0_data", 16'(vram_data), 16'd3);
        applyStimulus(1'b1, 4'd11, 1'b1, 1'b0);
        checkVal("vstart_d11_data", 16'(vram_data), 16'd0);

`ifdef PIX_QUANTIZER_DITHER_EN
        applyStimulus(1'b1, 4'd5, 1'b1, 1'b0);
        checkVal("dither_00", 16'(vram_data), 16'd2);
        applyStimulus(1'b1, 4'd5, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'd5, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'd5, 1'b0, 1'b1);
        checkVal("dither_03_addr", vram_addr, 16'h0300);
        checkVal("dither_03", 16'(vram_data), 16'd1);
`else
        applyStimulus(1'b1, 4'd6, 1'b1, 1'b0);
        checkVal("round_v6_a", 16'(vram_data), 16'd1);
        applyStimulus(1'b1, 4'd6, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd6, 1'b0, 1'b1);
        checkVal("round_v6_b", 16'(vram_data), 16'd1);
        applyStimulus(1'b1, 4'd15, 1'b0, 1'b0);
        checkVal("round_v15", 16'(vram_data), 16'd0);
`endif

        // Both markers together behave as vstart.
        applyStimulus(1'b1, 4'd3, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd3, 1'b1, 1'b1);
        checkVal("both_markers_addr", vram_addr, 16'h0000);
        checkVal("both_markers_we", 16'(vram_we), 16'd1);

        // Randomised traffic with gaps and occasional line/frame markers.
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                          ($urandom_range(0, 499) == 0), ($urandom_range(0, 39) == 0));
        end

        // Saturation: a very long line and very many lines must never wrap back into range.
        applyStimulus(1'b1, 4'd7, 1'b1, 1'b0);
        for (int i = 0; i < 270; i++) applyStimulus(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
        for (int i = 0; i < 260; i++) applyStimulus(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b1);

        // Full frame with one extra pixel per line and one extra line.
        strobeCount = 0; fdCount = 0; fdAddr = 16'h0;
        for (int l = 0; l <= V; l++) begin
            for (int p = 0; p <= H; p++) begin
                applyStimulus(1'b1, 4'($urandom_range(0, 15)), (l == 0 && p == 0), (l > 0 && p == 0));
                if (l == 0 && p == H) checkVal("pixel_161_no_we", 16'(vram_we), 16'd0);
            end
        end
        checkVal("frame_strobes", 16'(strobeCount), 16'(H * V));
        checkVal("frame_done_count", 16'(fdCount), 16'd1);
        checkVal("frame_done_addr", fdAddr, 16'h8F9F);

        // Mid-line reset discards the pending write and forces a wait for vstart.
        applyStimulus(1'b1, 4'd4, 1'b1, 1'b0);
        applyStimulus(1'b1, 4'd4, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd4, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkVal("midreset_we", 16'(vram_we), 16'd0);
        checkVal("midreset_addr", vram_addr, 16'h0000);
        checkVal("midreset_data", 16'(vram_data), 16'd0);
        @(posedge clk_8m);
        #1;
        rst_n = 1'b1;
        strobeCount = 0;
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 4'($urandom_range(0, 15)), 1'b0, (i % 7 == 3));
        checkVal("post_reset_strobes", 16'(strobeCount), 16'd0);
        applyStimulus(1'b1, 4'd0, 1'b1, 1'b0);
        checkVal("post_reset_vstart_we", 16'(vram_we), 16'd1);
        checkVal("post_reset_vstart_addr", vram_addr, 16'h0000);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pix_quantizer.md
PIX_QUANTIZER -- requirements
Module: pix_quantizer

Interface
REQ-001 SHALL have parameters: H_ACTIVE, 160, visible pixels per line; V_ACTIVE, 144, visible lines per frame.
REQ-002 SHALL have ports: clk_8m  in  1  sole clock; all logic on rising edge.
REQ-003 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: in_valid  in  1  one pixel offered this cycle; always accepted.
REQ-005 SHALL have ports: in_data  in  4  pixel luminance, nominal 0..11.
REQ-006 SHALL have ports: in_vstart  in  1  qualifies in_valid; pixel is first of frame.
REQ-007 SHALL have ports: in_hstart  in  1  qualifies in_valid; pixel is first of a non-first line.
REQ-008 SHALL have ports: vram_addr  out  16  write address {y[7:0], x[7:0]}, matching the LCD read address layout.
REQ-009 SHALL have ports: vram_data  out  2  DMG shade, 0 lightest, 3 darkest.
REQ-010 SHALL have ports: vram_we  out  1  single-cycle write strobe.
REQ-011 SHALL have ports: frame_done  out  1  single-cycle pulse on the write of pixel (H_ACTIVE-1, V_ACTIVE-1).

Function
REQ-012 SHALL keep 8-bit counters x, y and a sync flag; pixels are accepted only when in_valid=1.
REQ-013 SHALL, for an accepted pixel with in_vstart=1, set x=0, y=0, sync=1; in_vstart dominates in_hstart.
REQ-014 SHALL, with in_hstart=1 only, set x=0 and y=y+1, saturating at 255.
REQ-015 SHALL, with neither marker, set x=x+1, saturating at 255.
REQ-016 SHALL write only if sync=1, x<H_ACTIVE and y<V_ACTIVE for that pixel's coordinates; other pixels are silently dropped.
REQ-017 SHALL clamp in_data values 12..15 to 11 before quantisation.
REQ-018 SHALL compute d (0..11) as described in Configuration, then q = min(3, floor((v*4 + d)/12)), then vram_data = 3 - q.
REQ-019 SHALL register vram_addr, vram_data and vram_we so the strobe appears exactly 1 cycle after the accepting edge; back-to-back pixels produce back-to-back strobes.
REQ-020 SHALL hold vram_addr and vram_data at their last values when vram_we=0.
REQ-021 SHALL assert frame_done in the same cycle as the vram_we for pixel (H_ACTIVE-1, V_ACTIVE-1).

Reset
REQ-022 SHALL clear x, y, sync, vram_addr, vram_data, vram_we and frame_done to 0 on reset assertion.
REQ-023 SHALL drop all pixels after reset, including after a mid-frame reset, until the next in_vstart.
REQ-024 SHALL lose any write pending in the output register when reset occurs.

Configuration
REQ-025 SHALL, with PIX_QUANTIZER_DITHER_EN defined, use d = (B*3)>>2, where B is the 4x4 Bayer entry at [y[1:0]][x[1:0]]. Rows: 0,8,2,10 / 12,4,14,6 / 3,11,1,9 / 15,7,13,5.
REQ-026 SHALL, without PIX_QUANTIZER_DITHER_EN, use the constant d = 6 (plain rounding) and synthesize no Bayer table.

Structure
REQ-027 SHALL place H_ACTIVE/V_ACTIVE defaults, the Bayer table and the shade encoding in shared package dmgplus_pkg.
REQ-028 SHALL be a single module; the quantiser arithmetic may be a combinational function, and no sub-module is needed.

Verification
REQ-029 SHALL test: vstart pixel with data 0 -> next cycle we=1, addr 0x0000, data 3; data 11 -> data 0.
REQ-030 SHALL test, dither off: v=6 anywhere -> data 1; v=15 -> data 0 (clamped).
REQ-031 SHALL test, dither on: v=5 at (0,0) -> data 2; v=5 at (0,3) [y=3, x=0, B=15] -> data 1.
REQ-032 SHALL test: a full 160x144 frame -> exactly 23040 strobes and frame_done with addr 0x8F9F; 161st pixel of a line and 145th line -> no strobe.
REQ-033 SHALL test: rst_n pulsed mid-line, then pixels without vstart -> no strobes until vstart, which writes at 0x0000.
REQ-034 SHALL test: in_vstart and in_hstart both set -> treated as vstart (addr 0x0000).
